// File: rtl/counter_ctrl_8bit_if.sv
// Button/switch inputs and counter control outputs of counter_ctrl_8bit.
// slave = the control stage, master = whatever drives the buttons and watches the outputs.
interface counter_ctrl_8bit_if;
  logic       btn_ss;
  logic       btn_ld;
  logic [7:0] sw;
  logic       s_s;
  logic       l;
  logic [7:0] d;
  logic [1:0] state;

  modport slave (
    input  btn_ss, btn_ld, sw,
    output s_s, l, d, state
  );

  modport master (
    output btn_ss, btn_ld, sw,
    input  s_s, l, d, state
  );
endinterface

// File: rtl/counter_ctrl_8bit.sv
// Debounces start/stop and load buttons into s_s level, one-cycle l strobe and captured d for counter_8bit.
// Optional macro CTRL_LOAD_STOPS_EN: a load while running leaves the counter halted (RUN -> LOAD_S -> STOP).
module counter_ctrl_8bit #(
  parameter int DB_CYCLES = 16
) (
  input logic                 clk,
  input logic                 clr,
  counter_ctrl_8bit_if.slave  bus
);

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    RUN    = 2'b01,
    LOAD_S = 2'b10,
    LOAD_R = 2'b11
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'(DB_CYCLES - 1);

  // Bit 0 is the start/stop button, bit 1 the load button.
  logic [1:0]  btn_raw;
  logic [1:0]  s1_q, s2_q;
  logic [1:0]  db_q, db_d;
  logic [1:0]  db_dly_q;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  logic [1:0]  press;

  state_e      state_q, state_d;
  logic        s_s_q, s_s_d;
  logic        l_q, l_d;
  logic [7:0]  d_q, d_d;

  assign btn_raw = {bus.btn_ld, bus.btn_ss};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  // Load press takes priority; a coincident start/stop press is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (press[1])      state_d = LOAD_S;
        else if (press[0]) state_d = RUN;
      end
      RUN: begin
`ifdef CTRL_LOAD_STOPS_EN
        if (press[1])      state_d = LOAD_S;
`else
        if (press[1])      state_d = LOAD_R;
`endif
        else if (press[0]) state_d = STOP;
      end
      LOAD_S:  state_d = STOP;
      LOAD_R:  state_d = RUN;
      default: state_d = STOP;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as state_q.
  always_comb begin
    s_s_d = (state_d == RUN) || (state_d == LOAD_R);
    l_d   = (state_d == LOAD_S) || (state_d == LOAD_R);
    d_d   = l_d ? bus.sw : d_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      state_q  <= STOP;
      s_s_q    <= 1'b0;
      l_q      <= 1'b0;
      d_q      <= 8'h00;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      s_s_q    <= s_s_d;
      l_q      <= l_d;
      d_q      <= d_d;
    end
  end

  assign bus.s_s   = s_s_q;
  assign bus.l     = l_q;
  assign bus.d     = d_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_counter_ctrl_8bit.sv
// Scoreboard bench for counter_ctrl_8bit with DB_CYCLES=4: stimulus queues each expected output change
// with its cycle; a negedge monitor pops and compares whenever the outputs change.
module tb_counter_ctrl_8bit;

  localparam int DB = 4;
  localparam int LAT = DB + 3;

  logic clk;
  logic clr;
  int   cyc;
  int   n_chk;
  int   n_err;
  bit   mon_en;

  counter_ctrl_8bit_if bus ();

  counter_ctrl_8bit #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    int         cyc;
    logic       s_s;
    logic       l;
    logic [7:0] d;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int dcyc, input logic s_s, input logic l,
                           input logic [7:0] d, input logic [1:0] st);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.s_s = s_s;
    e.l   = l;
    e.d   = d;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_s"},   32'(bus.s_s),   32'd0);
    chk({tag, "_l"},     32'(bus.l),     32'd0);
    chk({tag, "_d"},     32'(bus.d),     32'd0);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
  endtask

  // Monitor: any change in the output vector must match the next queued expectation.
  logic [11:0] prev_v;
  logic [11:0] cur_v;
  always @(negedge clk) begin
    exp_t e;
    cur_v = {bus.s_s, bus.l, bus.d, bus.state};
    if (mon_en && (cur_v !== prev_v)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_change at cycle %0d: got %h expected %h", cyc, cur_v, prev_v);
      end else begin
        e = exp_q.pop_front();
        chk("change_cycle", 32'(cyc),       32'(e.cyc));
        chk("s_s",          32'(bus.s_s),   32'(e.s_s));
        chk("l",            32'(bus.l),     32'(e.l));
        chk("d",            32'(bus.d),     32'(e.d));
        chk("state",        32'(bus.state), 32'(e.st));
      end
    end
    prev_v = cur_v;
  end

  initial begin
    bit         running;
    logic [7:0] exp_d;
    n_chk  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    exp_d  = 8'h00;

    // Reset with both buttons held and switches set.
    clr        = 1'b1;
    bus.btn_ss = 1'b1;
    bus.btn_ld = 1'b1;
    bus.sw     = 8'hCD;
    step(1);
    chk_reset_outputs("rst_edge1");
    step(1);
    chk_reset_outputs("rst_edge2");
    mon_en     = 1'b1;
    clr        = 1'b0;
    bus.btn_ld = 1'b0;
    // btn_ss held through reset release is a press once debounced.
    expect_at(LAT, 1'b1, 1'b0, exp_d, 2'b01);
    step(12);

    // Start/stop: release, then press again to stop.
    bus.btn_ss = 1'b0;
    step(12);
    bus.btn_ss = 1'b1;
    expect_at(LAT, 1'b0, 1'b0, exp_d, 2'b00);
    step(12);
    bus.btn_ss = 1'b0;
    step(12);

    // Bounce: high 2, low 1, high 3, low 1, then steady high.
    bus.btn_ss = 1'b1; step(2);
    bus.btn_ss = 1'b0; step(1);
    bus.btn_ss = 1'b1; step(3);
    bus.btn_ss = 1'b0; step(1);
    bus.btn_ss = 1'b1;
    expect_at(LAT, 1'b1, 1'b0, exp_d, 2'b01);
    step(12);
    bus.btn_ss = 1'b0;
    step(12);

    // Load from RUN.
    bus.sw     = 8'hCD;
    bus.btn_ld = 1'b1;
    exp_d      = 8'hCD;
`ifdef CTRL_LOAD_STOPS_EN
    expect_at(LAT,     1'b0, 1'b1, exp_d, 2'b10);
    expect_at(LAT + 1, 1'b0, 1'b0, exp_d, 2'b00);
    running = 1'b0;
`else
    expect_at(LAT,     1'b1, 1'b1, exp_d, 2'b11);
    expect_at(LAT + 1, 1'b1, 1'b0, exp_d, 2'b01);
    running = 1'b1;
`endif
    step(LAT + 2);
    // Switch changes outside a load must not reach d.
    bus.sw = 8'h12;
    step(3);
    bus.btn_ld = 1'b0;
    step(12);

    if (running) begin
      bus.btn_ss = 1'b1;
      expect_at(LAT, 1'b0, 1'b0, exp_d, 2'b00);
      step(12);
      bus.btn_ss = 1'b0;
      step(12);
    end

    // Simultaneous presses in STOP: load wins, start/stop press dropped.
    bus.sw     = 8'h5A;
    bus.btn_ss = 1'b1;
    bus.btn_ld = 1'b1;
    exp_d      = 8'h5A;
    expect_at(LAT,     1'b0, 1'b1, exp_d, 2'b10);
    expect_at(LAT + 1, 1'b0, 1'b0, exp_d, 2'b00);
    step(12);
    bus.btn_ss = 1'b0;
    bus.btn_ld = 1'b0;
    step(12);

    // Reset during the load cycle.
    bus.btn_ss = 1'b1;
    expect_at(LAT, 1'b1, 1'b0, exp_d, 2'b01);
    step(12);
    bus.btn_ss = 1'b0;
    step(12);
    bus.sw     = 8'h77;
    bus.btn_ld = 1'b1;
`ifdef CTRL_LOAD_STOPS_EN
    expect_at(LAT, 1'b0, 1'b1, 8'h77, 2'b10);
`else
    expect_at(LAT, 1'b1, 1'b1, 8'h77, 2'b11);
`endif
    step(LAT);
    clr        = 1'b1;
    bus.btn_ld = 1'b0;
    expect_at(1, 1'b0, 1'b0, 8'h00, 2'b00);
    step(1);
    chk_reset_outputs("rst_mid_load");
    step(1);
    clr = 1'b0;
    step(12);

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_8bit.md
# counter_ctrl_8bit

Front-end control stage for `counter_8bit`. It turns two raw, bouncing push-buttons and an 8-bit switch bank into the counter's control inputs:
- a level `s_s` (start/stop) that toggles on each start/stop press;
- a single-cycle load strobe `l`, with the load value presented on `d`.

It sits directly upstream of the counter and drives its `s_s`, `l` and `d` ports. It shares the counter's `clk` and `clr`.

## Interface
- `DB_CYCLES`, default 16: number of consecutive cycles a synchronised button level must differ from its debounced level before it is accepted. Legal range 1..65535; the debounce counter is 16 bits.
- `clk` in 1: single clock. All logic is on the rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `btn_ss` in 1: raw start/stop button, asynchronous, may bounce.
- `btn_ld` in 1: raw load button, asynchronous, may bounce.
- `sw` in 8: load value switches, quasi-static.
- `s_s` out 1: run enable to the counter.
- `l` out 1: load strobe to the counter, one cycle wide.
- `d` out 8: load value to the counter, registered.
- `state` out 2: FSM state for debug. STOP=00, RUN=01, LOAD_S=10, LOAD_R=11.

## Operation
- **Synchronisers.** Each button passes through two flops (`s1`, `s2`).
- **Debouncer (per button).** Holds a stable level `db` and a 16-bit counter `cnt`.
  - If `s2 == db`: `cnt` <= 0.
  - Otherwise, if `cnt == DB_CYCLES-1`: `db` <= `s2` and `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt+1`.
- **Press event.** `db` & ~`db_q`, where `db_q` is `db` delayed one cycle. The event is one cycle wide. Button release generates no event.
- **FSM transitions**, evaluated on press events:
  - STOP: ld press -> LOAD_S; else ss press -> RUN.
  - RUN: ld press -> LOAD_R; else ss press -> STOP.
  - LOAD_S -> STOP unconditionally.
  - LOAD_R -> RUN unconditionally.
- **Outputs are registered and decoded from the next state**, so they change on the same edge as the state.
  - `s_s` = 1 in RUN and LOAD_R.
  - `l` = 1 in LOAD_S and LOAD_R.
- **`d` capture.** `d` <= `sw` on the edge that enters LOAD_*. `d` holds that value until the next load; `sw` changes at other times do not affect `d`.
- **Simultaneous ss and ld press in one cycle.** Load wins. The ss press is discarded, not queued.
- **Press events while in LOAD_S or LOAD_R** are ignored.
- **Reset (`clr`=1 at an edge).** State STOP; `s_s`=0, `l`=0, `d`=8'h00, `state`=00. All `s1`/`s2`/`db`/`db_q`/`cnt` registers are cleared. Reset has priority over every event, including mid-debounce and mid-LOAD.
- **Button held through reset release.** This produces a press once it has been debounced, because `db` restarts at 0.

## Timing
- **Press latency.** Count the first edge that samples a raw button high as edge 1. The press takes effect on `s_s`/`l`/`state` at edge `DB_CYCLES+3`:
  - 2 cycles for the synchronisers;
  - `DB_CYCLES` cycles for the debouncer;
  - 1 cycle for edge detection and the FSM.
- **Bounce rejection.** Any return of `s2` to `db` before `DB_CYCLES` consecutive differing cycles restarts the count. A glitch shorter than `DB_CYCLES` cycles produces nothing.
- **`l` width.** Exactly 1 cycle. `d` is valid in the same cycle as `l` and remains valid afterwards.
- **Load from RUN** (without macro): `s_s` stays 1 continuously through LOAD_R.
- **Minimum spacing** between two accepted presses of the same button: 2·`DB_CYCLES` cycles.

## Configuration
- Macro `CTRL_LOAD_STOPS_EN`.
- **Defined:** an ld press in RUN goes to LOAD_S instead of LOAD_R.
  - `s_s` falls on the same edge that `l` rises.
  - The FSM then returns to STOP, so the counter is left halted at the loaded value.
  - LOAD_R is unreachable.
- **Undefined:** behaviour as described above; loading while running resumes counting.

## Test plan
All scenarios use `DB_CYCLES`=4.
- **Reset.** Drive `clr`=1 for 2 cycles with buttons high and `sw`=8'hCD -> `s_s`=0, `l`=0, `d`=00, `state`=00 throughout. After release with `btn_ss` still high, `s_s` rises at edge 7.
- **Start/stop.** Clean `btn_ss` press from STOP -> `s_s` rises at edge 7 after the first sampling edge. Release, then press again -> `s_s` falls after the same latency.
- **Bounce.** `btn_ss` pattern high 2, low 1, high 3, low 1, then steady high -> exactly one `s_s` toggle, occurring 7 edges after the start of the steady-high period.
- **Load from RUN.** In RUN with `sw`=8'hCD, press `btn_ld` -> `l` high for exactly 1 cycle, `d`=8'hCD, `s_s` stays 1, `state` goes 11 then 01. With `CTRL_LOAD_STOPS_EN` defined -> `s_s` falls with `l`, `state` goes 10 then 00.
- **Simultaneous presses.** Press both buttons on the same edge in STOP -> one `l` pulse, `s_s` stays 0, `state` ends at 00.
- **Reset mid-operation.** Assert `clr` in the LOAD_R cycle -> the next edge gives `l`=0, `s_s`=0, `d`=00, `state`=00.
